// File: rtl/pes_sipo_pkg.sv
// Shared types and helpers for the pes_sipo receiver: FSM state encoding and counter sizing.
package pes_sipo_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pes_sipo_hold.sv
// One-entry valid/ready holding register; a completed word that finds it full (and not
// draining this cycle) is dropped and reported with a one-cycle overrun pulse.
module pes_sipo_hold #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             ready,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             overrun
);

   logic drain;

   assign drain = valid & ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         dout    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= load & valid & ~ready;
         if (load && (!valid || ready)) begin
            dout  <= din;
            valid <= 1'b1;
         end else if (drain) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pes_sipo_rx.sv
// MSB-first serial deframer: start bit, WIDTH data bits, optional even parity, stop bit.
// Define PARITY_CHECK_EN to add the parity bit between the data bits and the stop bit.
module pes_sipo_rx
   import pes_sipo_pkg::*;
#(
   parameter int   WIDTH    = 4,
   parameter logic IDLE_LVL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [WIDTH-1:0]   shift, shift_nxt;
   logic               par_ok;
   logic               word_done;
   logic               stop_err;

`ifdef PARITY_CHECK_EN
   logic par_bit, par_nxt;

   // Even parity: data bits together with the parity bit must XOR to zero.
   assign par_ok = ~(^shift ^ par_bit);
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         shift     <= '0;
         frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         shift     <= shift_nxt;
         frame_err <= stop_err;
`ifdef PARITY_CHECK_EN
         par_bit   <= par_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shift_nxt = shift;
      word_done = 1'b0;
      stop_err  = 1'b0;
`ifdef PARITY_CHECK_EN
      par_nxt   = par_bit;
`endif
      if (bit_en) begin
         case (state)
            S_IDLE: begin
               if (serial_in == ~IDLE_LVL) begin
                  state_nxt = S_DATA;
                  cnt_nxt   = '0;
               end
            end
            S_DATA: begin
               shift_nxt = {shift[WIDTH-2:0], serial_in};
               cnt_nxt   = cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                  state_nxt = S_PARITY;
`else
                  state_nxt = S_STOP;
`endif
               end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
               par_nxt   = serial_in;
               state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
               // Back to IDLE either way so a start bit may follow immediately.
               if ((serial_in == IDLE_LVL) && par_ok) word_done = 1'b1;
               else                                   stop_err  = 1'b1;
               state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

   pes_sipo_hold #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load    (word_done),
      .din     (shift),
      .ready   (data_ready),
      .dout    (data_out),
      .valid   (data_valid),
      .overrun (overrun)
   );

endmodule

// File: tb/tb_pes_sipo_rx.sv
// Directed bench for pes_sipo_rx (WIDTH=4, IDLE_LVL=1); honours PARITY_CHECK_EN if defined.
module tb_pes_sipo_rx;

   logic       clk;
   logic       rst;
   logic       bit_en;
   logic       serial_in;
   logic [3:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   pes_sipo_rx #(
      .WIDTH    (4),
      .IDLE_LVL (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_en     (bit_en),
      .serial_in  (serial_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of line/strobe, then sample 1 time unit after the rising edge.
   task automatic step(input logic b, input logic en);
      serial_in = b;
      bit_en    = en;
      @(posedge clk);
      #1;
   endtask

   // Start bit plus MSB-first data (plus even parity when enabled); stop bit is sent by caller.
   task automatic send_data(input logic [3:0] d);
      step(1'b0, 1'b1);
      for (int i = 3; i >= 0; i--) step(d[i], 1'b1);
`ifdef PARITY_CHECK_EN
      step(^d, 1'b1);
`endif
   endtask

   task automatic tick3(input logic b);
      step(b, 1'b1);
      step(~b, 1'b0);
      step(~b, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"},  {4'h0, data_out}, 8'h00);
      check({tag, "_valid"}, {7'h0, data_valid}, 8'h00);
      check({tag, "_ferr"},  {7'h0, frame_err}, 8'h00);
      check({tag, "_ovr"},   {7'h0, overrun}, 8'h00);
      check({tag, "_busy"},  {7'h0, busy}, 8'h00);
   endtask

   initial begin
      logic [3:0] d4;
      rst        = 1'b1;
      bit_en     = 1'b0;
      serial_in  = 1'b1;
      data_ready = 1'b0;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check_all_zero("reset");
      rst = 1'b0;

      // 1: clean frame 1011 with consumer ready
      data_ready = 1'b1;
      step(1'b1, 1'b1);
      send_data(4'b1011);
      check("t1_busy_mid", {7'h0, busy}, 8'h01);
      check("t1_valid_pre", {7'h0, data_valid}, 8'h00);
      step(1'b1, 1'b1);
      check("t1_valid", {7'h0, data_valid}, 8'h01);
      check("t1_data", {4'h0, data_out}, 8'h0b);
      check("t1_ferr", {7'h0, frame_err}, 8'h00);
      check("t1_ovr", {7'h0, overrun}, 8'h00);
      check("t1_busy_end", {7'h0, busy}, 8'h00);
      step(1'b1, 1'b1);
      check("t1_drained", {7'h0, data_valid}, 8'h00);

      // 2: bad stop bit after 1100
      send_data(4'b1100);
      step(1'b0, 1'b1);
      check("t2_ferr", {7'h0, frame_err}, 8'h01);
      check("t2_valid", {7'h0, data_valid}, 8'h00);
      check("t2_busy", {7'h0, busy}, 8'h00);
      step(1'b1, 1'b1);
      check("t2_ferr_pulse", {7'h0, frame_err}, 8'h00);
      check("t2_idle", {7'h0, busy}, 8'h00);

      // 3: back-to-back frames with consumer stalled
      data_ready = 1'b0;
      send_data(4'b1011);
      step(1'b1, 1'b1);
      check("t3_valid1", {7'h0, data_valid}, 8'h01);
      check("t3_data1", {4'h0, data_out}, 8'h0b);
      send_data(4'b0110);
      step(1'b1, 1'b1);
      check("t3_ovr", {7'h0, overrun}, 8'h01);
      check("t3_held", {4'h0, data_out}, 8'h0b);
      check("t3_valid_held", {7'h0, data_valid}, 8'h01);
      step(1'b1, 1'b1);
      check("t3_ovr_pulse", {7'h0, overrun}, 8'h00);
      check("t3_still", {4'h0, data_out}, 8'h0b);
      data_ready = 1'b1;
      step(1'b1, 1'b1);
      check("t3_drain", {7'h0, data_valid}, 8'h00);

      // 4: strobe every third cycle with glitches in between
      step(1'b0, 1'b0);
      check("t4_glitch_idle", {7'h0, busy}, 8'h00);
      d4 = 4'b1001;
      tick3(1'b0);
      check("t4_busy", {7'h0, busy}, 8'h01);
      for (int i = 3; i >= 0; i--) tick3(d4[i]);
`ifdef PARITY_CHECK_EN
      tick3(^d4);
`endif
      check("t4_valid_pre", {7'h0, data_valid}, 8'h00);
      step(1'b1, 1'b1);
      check("t4_valid", {7'h0, data_valid}, 8'h01);
      check("t4_data", {4'h0, data_out}, 8'h09);
      check("t4_ferr", {7'h0, frame_err}, 8'h00);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("t4_drain", {7'h0, data_valid}, 8'h00);
      check("t4_no_start", {7'h0, busy}, 8'h00);

      // 5: reset drops both a held word and a partial frame
      data_ready = 1'b0;
      send_data(4'b0110);
      step(1'b1, 1'b1);
      check("t5_held", {4'h0, data_out}, 8'h06);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      rst = 1'b1;
      step(1'b1, 1'b1);
      check_all_zero("t5_rst");
      rst = 1'b0;
      data_ready = 1'b1;
      step(1'b1, 1'b1);
      check_all_zero("t5_post");
      send_data(4'b0111);
      step(1'b1, 1'b1);
      check("t5_valid", {7'h0, data_valid}, 8'h01);
      check("t5_data", {4'h0, data_out}, 8'h07);
      check("t5_ferr", {7'h0, frame_err}, 8'h00);
      step(1'b1, 1'b1);

`ifdef PARITY_CHECK_EN
      // 6: parity bit good (1) then bad (0) for data 1011
      step(1'b0, 1'b1);
      step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("t6_good_valid", {7'h0, data_valid}, 8'h01);
      check("t6_good_data", {4'h0, data_out}, 8'h0b);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      check("t6_bad_ferr", {7'h0, frame_err}, 8'h01);
      check("t6_bad_valid", {7'h0, data_valid}, 8'h00);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
